// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared defaults, the zero-register index and the write-port
//           priority helper for the multi-port register file.
// Revision: 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int REG_ZERO       = 0;

    // Which source a read port returns when a write targets its address
    typedef enum logic [1:0] {
        SEL_ARRAY = 2'b00,
        SEL_WD0   = 2'b01,
        SEL_WD1   = 2'b10
    } wr_sel_e;

    // Port 1 (late unit) outranks port 0 (WB) whenever both hit
    function automatic wr_sel_e wr_sel(input logic hit0, input logic hit1);
        if (hit1) begin
            return SEL_WD1;
        end else if (hit0) begin
            return SEL_WD0;
        end
        return SEL_ARRAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_bypass.sv
`default_nettype none
// ============================================================================
// Module  : regfile_rd_bypass
// Purpose : One combinational read port with same-cycle write forwarding.
//           Also reports whether a write targets this port's address so the
//           caller can hide a stale busy bit.
// Revision: 1.0  initial release
// ============================================================================
module regfile_rd_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int ZERO_R0 = 1
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] arr_word,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rd,
    output logic              wr_hit
);

    logic    w_hit0;
    logic    w_hit1;
    logic    w_is_r0;
    wr_sel_e w_sel;

    assign w_hit0  = we0 && (wa0 == ra);
    assign w_hit1  = we1 && (wa1 == ra);
    assign w_is_r0 = (ZERO_R0 != 0) && (ra == ADDR_W'(REG_ZERO));
    assign w_sel   = wr_sel(w_hit0, w_hit1);

    // Hardwired zero first, then forwarded write data, then stored word
    always_comb begin
        rd     = arr_word;
        wr_hit = 1'b0;
        if (w_is_r0) begin
            rd = '0;
        end else begin
            wr_hit = w_hit0 | w_hit1;
            case (w_sel)
                SEL_WD1: rd = wd1;
                SEL_WD0: rd = wd0;
                default: rd = arr_word;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : regfile_mp
// Purpose : Parametrised multi-port register file: NUM_RD bypassed read
//           ports, two write ports (port 1 wins on collision), per-register
//           busy scoreboard and a registered debug read port.
// Revision: 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int NUM_RD  = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    localparam int DEPTH = 2**ADDR_W;

    generate
        if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
            $error("regfile_mp: NUM_RD must be in 1..4");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [DATA_W-1:0] r_dbg_data;

    // Effective enables: traffic aimed at a hardwired r0 is discarded
    logic w_we0;
    logic w_we1;
    logic w_rsv;

    assign w_we0 = we0    && !((ZERO_R0 != 0) && (wa0      == ADDR_W'(REG_ZERO)));
    assign w_we1 = we1    && !((ZERO_R0 != 0) && (wa1      == ADDR_W'(REG_ZERO)));
    assign w_rsv = rsv_en && !((ZERO_R0 != 0) && (rsv_addr == ADDR_W'(REG_ZERO)));

    // Storage: reset sweep clears every word; port 1 is applied last so it wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            if (w_we0) begin
                r_mem[wa0] <= wd0;
            end
            if (w_we1) begin
                r_mem[wa1] <= wd1;
            end
        end
    end

    // Scoreboard next state: writes clear, a reservation set overrides them
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we0) begin
            w_busy_nxt[wa0] = 1'b0;
        end
        if (w_we1) begin
            w_busy_nxt[wa1] = 1'b0;
        end
        if (w_rsv) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Debug port samples the pre-edge array without forwarding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dbg_data <= '0;
        end else if ((ZERO_R0 != 0) && (dbg_addr == ADDR_W'(REG_ZERO))) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_mem[dbg_addr];
        end
    end

    assign dbg_data = r_dbg_data;

    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
            logic [ADDR_W-1:0] w_ra;
            logic              w_hit;

            assign w_ra = ra[i*ADDR_W +: ADDR_W];

            regfile_rd_bypass #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_R0 (ZERO_R0)
            ) u_rd (
                .ra       (w_ra),
                .arr_word (r_mem[w_ra]),
                .we0      (we0),
                .wa0      (wa0),
                .wd0      (wd0),
                .we1      (we1),
                .wa1      (wa1),
                .wd1      (wd1),
                .rd       (rd[i*DATA_W +: DATA_W]),
                .wr_hit   (w_hit)
            );

            // A same-cycle write to the address retires the reservation early
            assign rd_busy[i] = r_busy[w_ra] & ~w_hit &
                                ~((ZERO_R0 != 0) && (w_ra == ADDR_W'(REG_ZERO)));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_mp
// Purpose : Directed, table-driven self-checking bench for regfile_mp.
// Revision: 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rd_busy;
    logic             we0, we1, rsv_en;
    logic [AW-1:0]    wa0, wa1, rsv_addr, dbg_addr;
    logic [DW-1:0]    wd0, wd1, dbg_data;

    logic [AW-1:0]    ra0, ra1, ra2;

    int n_checks = 0;
    int n_fail   = 0;

    assign ra = {ra2, ra1, ra0};

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    typedef struct {
        logic          we0;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          rsv;
        logic [AW-1:0] rsva;
        logic [AW-1:0] ra0;
        logic [AW-1:0] ra1;
        logic [AW-1:0] dbga;
        logic [DW-1:0] exp_rd0;
        logic          exp_bz0;
        logic [DW-1:0] exp_rd1;
        logic          exp_bz1;
        logic [DW-1:0] exp_dbg;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic rv, input logic [AW-1:0] rva,
        input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] dg,
        input logic [DW-1:0] e0, input logic b0,
        input logic [DW-1:0] e1, input logic b1,
        input logic [DW-1:0] ed);
        vec_t v;
        v.we0 = w0; v.wa0 = a0; v.wd0 = d0;
        v.we1 = w1; v.wa1 = a1; v.wd1 = d1;
        v.rsv = rv; v.rsva = rva;
        v.ra0 = r0; v.ra1 = r1; v.dbga = dg;
        v.exp_rd0 = e0; v.exp_bz0 = b0;
        v.exp_rd1 = e1; v.exp_bz1 = b1;
        v.exp_dbg = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        ra0 = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;

        //         we0 wa0 wd0           we1 wa1 wd1      rsv rsva ra0 ra1 dbg  exp_rd0       b0 exp_rd1       b1 exp_dbg
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,         0, 0,   5,  6,  5,   32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,         0, 0,   5,  0,  7,   32'hDEADBEEF, 0, 32'h0,        0, 32'h0);
        tbl[2]  = mk(1, 7, 32'h1,        1, 7, 32'h2,     0, 0,   7,  5,  5,   32'h2,        0, 32'hDEADBEEF, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,         0, 0,   7,  5,  7,   32'h2,        0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0,         1, 9,   9,  7,  0,   32'h0,        0, 32'h2,        0, 32'h2);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,         0, 0,   9,  9,  0,   32'h0,        1, 32'h0,        1, 32'h0);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0,         0, 0,   9,  9,  0,   32'h0,        1, 32'h0,        1, 32'h0);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,         0, 0,   9,  9,  0,   32'h0,        1, 32'h0,        1, 32'h0);
        tbl[8]  = mk(0, 0, 0,            1, 9, 32'h55,    0, 0,   9,  9,  0,   32'h55,       0, 32'h55,       0, 32'h0);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,         0, 0,   9,  9,  0,   32'h55,       0, 32'h55,       0, 32'h0);
        tbl[10] = mk(1, 3, 32'hABCD,     0, 0, 0,         1, 3,   3,  9,  3,   32'hABCD,     0, 32'h55,       0, 32'h0);
        tbl[11] = mk(0, 0, 0,            0, 0, 0,         0, 0,   3,  3,  3,   32'hABCD,     1, 32'hABCD,     1, 32'h0);
        tbl[12] = mk(0, 0, 0,            0, 0, 0,         0, 0,   3,  9,  3,   32'hABCD,     1, 32'h55,       0, 32'hABCD);
        tbl[13] = mk(1, 0, 32'hFFFF,     0, 0, 0,         1, 0,   0,  3,  0,   32'h0,        0, 32'hABCD,     1, 32'hABCD);
        tbl[14] = mk(0, 0, 0,            0, 0, 0,         0, 0,   0,  3,  0,   32'h0,        0, 32'hABCD,     1, 32'h0);
        tbl[15] = mk(1, 3, 32'h77,       0, 0, 0,         0, 0,   3,  0,  0,   32'h77,       0, 32'h0,        0, 32'h0);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,         0, 0,   3,  7,  0,   32'h77,       0, 32'h2,        0, 32'h0);
        tbl[17] = mk(1, 10, 32'hA,       1, 11, 32'hB,    0, 0,   10, 11, 0,   32'hA,        0, 32'hB,        0, 32'h0);

        // Reset cycle, then sweep every address on both read ports and debug
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra0 = AW'(i); ra2 = AW'(i); dbg_addr = AW'(i);
            #1;
            chk($sformatf("reset rd0 r%0d", i), rd[0*DW +: DW], 32'h0);
            chk($sformatf("reset rd2 r%0d", i), rd[2*DW +: DW], 32'h0);
            chk($sformatf("reset busy r%0d", i), {31'h0, rd_busy[0]}, 32'h0);
            if (i > 0) begin
                chk($sformatf("reset dbg r%0d", i - 1), dbg_data, 32'h0);
            end
            @(negedge clk);
        end
        dbg_addr = '0;
        ra2 = '0;
        #1;
        chk("reset dbg r31", dbg_data, 32'h0);

        // Table rows: drive at negedge, check combinational outputs before the edge
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
            we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
            rsv_en = tbl[i].rsv; rsv_addr = tbl[i].rsva;
            ra0 = tbl[i].ra0; ra1 = tbl[i].ra1; dbg_addr = tbl[i].dbga;
            #1;
            chk($sformatf("row%0d rd0", i), rd[0*DW +: DW], tbl[i].exp_rd0);
            chk($sformatf("row%0d busy0", i), {31'h0, rd_busy[0]}, {31'h0, tbl[i].exp_bz0});
            chk($sformatf("row%0d rd1", i), rd[1*DW +: DW], tbl[i].exp_rd1);
            chk($sformatf("row%0d busy1", i), {31'h0, rd_busy[1]}, {31'h0, tbl[i].exp_bz1});
            chk($sformatf("row%0d dbg", i), dbg_data, tbl[i].exp_dbg);
        end

        // Reset mid-operation: same-cycle write and reservation must not land
        @(negedge clk);
        idle_inputs();
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hCAFE;
        rsv_en = 1'b1; rsv_addr = 5'd13;
        ra0 = 5'd12; ra1 = 5'd13; dbg_addr = 5'd5;
        #1;
        chk("pre-rst rd0 bypass", rd[0*DW +: DW], 32'hCAFE);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h1234;
        rsv_en = 1'b1; rsv_addr = 5'd12;
        #1;
        chk("in-rst rd0 bypass", rd[0*DW +: DW], 32'h1234);
        chk("in-rst busy1 r13", {31'h0, rd_busy[1]}, 32'h1);
        chk("in-rst dbg r5", dbg_data, 32'hDEADBEEF);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        ra2 = 5'd5;
        #1;
        chk("post-rst rd0 r12", rd[0*DW +: DW], 32'h0);
        chk("post-rst busy0 r12", {31'h0, rd_busy[0]}, 32'h0);
        chk("post-rst busy1 r13", {31'h0, rd_busy[1]}, 32'h0);
        chk("post-rst rd2 r5", rd[2*DW +: DW], 32'h0);
        chk("post-rst dbg", dbg_data, 32'h0);

        // Port 2 forwarding and persistence
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h99;
        ra2 = 5'd20; dbg_addr = 5'd20;
        #1;
        chk("p2 bypass r20", rd[2*DW +: DW], 32'h99);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("p2 stored r20", rd[2*DW +: DW], 32'h99);
        chk("dbg pre-edge r20", dbg_data, 32'h0);
        @(negedge clk);
        #1;
        chk("dbg r20", dbg_data, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
